// File: rtl/cnn_stream_pkg.sv
// Shared types and sizing helpers for the streaming CNN datapath blocks.
package cnn_stream_pkg;

  typedef enum logic {IDLE, SEND} ser_state_e;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

  function automatic int unsigned beats_of(input int unsigned height, input int unsigned lanes);
    return ceil_div(height, lanes);
  endfunction

  // A single-beat frame still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/lane_select.sv
// Picks the words of the current beat out of the held vector; lanes past the end read as zero.
module lane_select #(
  parameter int unsigned LAYER_HEIGHT = 256,
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned LANES        = 1,
  parameter bit          REVERSE      = 1'b0,
  parameter int unsigned BEAT_W       = 1
) (
  input  logic                                   en,
  input  logic [BEAT_W-1:0]                      beat,
  input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] vec,
  output logic [LANES-1:0][WORD_SIZE-1:0]        data,
  output logic [LANES-1:0]                       keep
);

  localparam int unsigned IdxW = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1;

  always_comb begin
    data = '0;
    keep = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (en && ((32'(beat) * LANES + l) < LAYER_HEIGHT)) begin
        keep[l] = 1'b1;
        data[l] = vec[IdxW'(REVERSE ? (LAYER_HEIGHT - 1 - (32'(beat) * LANES + l))
                                    : (32'(beat) * LANES + l))];
      end
    end
  end

endmodule

// File: rtl/vector_serializer.sv
// Parallel-to-serial converter: latches a whole activation vector and writes it LANES words
// per beat into a downstream FIFO, with back-to-back frames and no bubble between them.
module vector_serializer
  import cnn_stream_pkg::*;
#(
  parameter int unsigned LAYER_HEIGHT = 256,
  parameter int unsigned WORD_SIZE    = 16,
  parameter int unsigned LANES        = 1,
  parameter bit          REVERSE      = 1'b0
) (
  input  logic                                   clk_i,
  input  logic                                   reset_ni,
  input  logic                                   valid_i,
  output logic                                   ready_o,
  input  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
  output logic                                   wen_o,
  input  logic                                   full_i,
  output logic [LANES-1:0][WORD_SIZE-1:0]        data_o,
  output logic [LANES-1:0]                       keep_o,
  output logic                                   last_o,
  output logic                                   busy_o
);

  localparam int unsigned Beats  = beats_of(LAYER_HEIGHT, LANES);
  localparam int unsigned BeatW  = cnt_width(Beats);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);

  ser_state_e                             state_q;
  logic [BeatW-1:0]                       cnt_q;
  logic [LAYER_HEIGHT-1:0][WORD_SIZE-1:0] vec_q;
  logic                                   sending;

  assign sending = (state_q == SEND);
  assign busy_o  = sending;
  assign last_o  = sending && (cnt_q == LastBeat);
  assign wen_o   = sending && !full_i;
  // Ready on the final beat so the next frame follows without a gap.
  assign ready_o = (state_q == IDLE) || (last_o && !full_i);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      vec_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            vec_q   <= data_i;
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (wen_o) begin
            if (last_o) begin
              cnt_q <= '0;
              if (valid_i) begin
                vec_q <= data_i;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  lane_select #(
    .LAYER_HEIGHT (LAYER_HEIGHT),
    .WORD_SIZE    (WORD_SIZE),
    .LANES        (LANES),
    .REVERSE      (REVERSE),
    .BEAT_W       (BeatW)
  ) u_lane_select (
    .en   (sending),
    .beat (cnt_q),
    .vec  (vec_q),
    .data (data_o),
    .keep (keep_o)
  );

endmodule
